// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // RUN: normal issue; MULT_WAIT: front end held while a multiply occupies ID.
    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } state_t;

    // Register $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_controller.sv
// Hazard controller for the 5-stage MIPS core: load-use stall, multi-cycle
// multiply hold, taken-branch squash and a saturating stall-cycle counter.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             ID_IsMult,
    input  logic             ID_BranchTaken,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic [CNT_W-1:0] StallCycles
);

    // The first multiply stall happens in RUN, so the wait loads one less.
    localparam logic [3:0] MCNT_INIT = 4'(MULT_CYCLES - 1);

    state_t           state;
    logic [3:0]       mcnt;
    logic             release_flag;
    logic [CNT_W-1:0] stall_cycles;

    logic             load_hz;
    logic             start_mult;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;

    assign load_hz = EX_MemRead && (EX_rt != REG_ZERO) &&
                     ((EX_rt == ID_rs) || (ID_UsesRt && (EX_rt == ID_rt)));

    // Control decode: load-use beats multiply beats branch; reset forces release.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        start_mult   = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (load_hz) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (ID_IsMult && !release_flag) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        start_mult   = 1'b1;
                    end else if (ID_BranchTaken) begin
                        if_id_flush  = 1'b1;
                    end
                end
                MULT_WAIT: begin
                    if (mcnt != 4'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    // Multiply sequencing; a one-cycle multiply uses the release flag instead of MULT_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            mcnt         <= 4'd0;
            release_flag <= 1'b0;
        end else begin
            release_flag <= 1'b0;
            case (state)
                RUN: begin
                    if (start_mult) begin
                        mcnt <= MCNT_INIT;
                        if (MULT_CYCLES == 1) begin
                            release_flag <= 1'b1;
                        end else begin
                            state <= MULT_WAIT;
                        end
                    end
                end
                MULT_WAIT: begin
                    if (mcnt != 4'd0) begin
                        mcnt <= mcnt - 4'd1;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles in which the IF/ID register was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!if_id_write && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign PCWrite      = pc_write;
    assign IF_ID_Write  = if_id_write;
    assign IF_ID_Flush  = if_id_flush;
    assign ID_EX_Bubble = id_ex_bubble;
    assign StallCycles  = stall_cycles;

endmodule
